// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for the IF/ID elastic buffer.
// The buffer connects through the slave modport; the fetch/decode side drives through master.
interface if_id_buffer_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
);
    logic                   f_valid;
    logic                   f_ready;
    logic [ADDR_WIDTH-1:0]  f_pc;
    logic [INSTR_WIDTH-1:0] f_instruction;
    logic                   flush;
    logic                   d_valid;
    logic                   d_ready;
    logic [ADDR_WIDTH-1:0]  d_pc;
    logic [INSTR_WIDTH-1:0] d_instruction;
    logic [ADDR_WIDTH-1:0]  d_pc_plus4;
    logic [1:0]             occupancy;

    modport slave (
        input  f_valid, f_pc, f_instruction, flush, d_ready,
        output f_ready, d_valid, d_pc, d_instruction, d_pc_plus4, occupancy
    );

    modport master (
        output f_valid, f_pc, f_instruction, flush, d_ready,
        input  f_ready, d_valid, d_pc, d_instruction, d_pc_plus4, occupancy
    );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID elastic FIFO with flush, masked outputs and a PC+4 link value.
// f_ready is derived from registered count only, so there is no path from d_ready.
module if_id_buffer #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    if_id_buffer_if.slave bus
);
    logic [ADDR_WIDTH-1:0]  r_pc    [2];
    logic [INSTR_WIDTH-1:0] r_instr [2];
    logic                   r_head;
    logic                   r_tail;
    logic [1:0]             r_count;

    logic w_f_ready;
    logic w_d_valid;
    logic w_push;
    logic w_pop;

    assign w_f_ready = (r_count != 2'd2);
    assign w_d_valid = (r_count != 2'd0);
    assign w_push    = bus.f_valid & w_f_ready & ~bus.flush;
    assign w_pop     = w_d_valid & bus.d_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
        end else if (bus.flush) begin
            // Any same-cycle pop counts as consumed; stored data is left as-is.
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc[r_tail]    <= bus.f_pc;
                r_instr[r_tail] <= bus.f_instruction;
                r_tail          <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    always_comb begin
        bus.d_pc          = '0;
        bus.d_instruction = '0;
        bus.d_pc_plus4    = '0;
        if (w_d_valid) begin
            bus.d_pc          = r_pc[r_head];
            bus.d_instruction = r_instr[r_head];
            bus.d_pc_plus4    = r_pc[r_head] + ADDR_WIDTH'(4);
        end
    end

    assign bus.f_ready   = w_f_ready;
    assign bus.d_valid   = w_d_valid;
    assign bus.occupancy = r_count;
endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer: handshake, back-pressure, streaming, flush, wrap, reset.
module tb_if_id_buffer;
    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    if_id_buffer_if #(.ADDR_WIDTH(64), .INSTR_WIDTH(32)) bus ();

    if_id_buffer #(.ADDR_WIDTH(64), .INSTR_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.f_valid       = 1'b0;
        bus.f_pc          = '0;
        bus.f_instruction = '0;
        bus.flush         = 1'b0;
        bus.d_ready       = 1'b0;
    endtask

    task automatic push_word(input logic [63:0] pc, input logic [31:0] ins);
        bus.f_valid       = 1'b1;
        bus.f_pc          = pc;
        bus.f_instruction = ins;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        #2;
        tests++; if (bus.d_valid !== 1'b0) begin fails++; $display("FAIL reset_d_valid got %0b exp 0", bus.d_valid); end
        tests++; if (bus.f_ready !== 1'b1) begin fails++; $display("FAIL reset_f_ready got %0b exp 1", bus.f_ready); end
        tests++; if (bus.occupancy !== 2'd0) begin fails++; $display("FAIL reset_occ got %0d exp 0", bus.occupancy); end
        tests++; if (bus.d_pc !== 64'h0) begin fails++; $display("FAIL reset_d_pc got %h exp 0", bus.d_pc); end
        tests++; if (bus.d_instruction !== 32'h0) begin fails++; $display("FAIL reset_d_instr got %h exp 0", bus.d_instruction); end
        tests++; if (bus.d_pc_plus4 !== 64'h0) begin fails++; $display("FAIL reset_pc4 got %h exp 0", bus.d_pc_plus4); end
        #10;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        push_word(64'h0, 32'h91000421);
        bus.d_ready = 1'b1;
        tick();
        bus.f_valid = 1'b0;
        tests++; if (bus.d_valid !== 1'b1) begin fails++; $display("FAIL single_d_valid got %0b exp 1", bus.d_valid); end
        tests++; if (bus.d_pc !== 64'h0) begin fails++; $display("FAIL single_d_pc got %h exp 0", bus.d_pc); end
        tests++; if (bus.d_instruction !== 32'h91000421) begin fails++; $display("FAIL single_d_instr got %h exp 91000421", bus.d_instruction); end
        tests++; if (bus.d_pc_plus4 !== 64'h4) begin fails++; $display("FAIL single_pc4 got %h exp 4", bus.d_pc_plus4); end
        tests++; if (bus.occupancy !== 2'd1) begin fails++; $display("FAIL single_occ got %0d exp 1", bus.occupancy); end
        tick();
        tests++; if (bus.d_valid !== 1'b0) begin fails++; $display("FAIL single_empty_valid got %0b exp 0", bus.d_valid); end
        tests++; if (bus.d_instruction !== 32'h0) begin fails++; $display("FAIL single_empty_instr got %h exp 0", bus.d_instruction); end
        tests++; if (bus.d_pc_plus4 !== 64'h0) begin fails++; $display("FAIL single_empty_pc4 got %h exp 0", bus.d_pc_plus4); end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        bus.d_ready = 1'b0;
        push_word(64'h0, 32'hA0);
        tick();
        tests++; if (bus.occupancy !== 2'd1) begin fails++; $display("FAIL bp_occ1 got %0d exp 1", bus.occupancy); end
        tests++; if (bus.f_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got %0b exp 1", bus.f_ready); end
        push_word(64'h4, 32'hA4);
        tick();
        tests++; if (bus.occupancy !== 2'd2) begin fails++; $display("FAIL bp_occ2 got %0d exp 2", bus.occupancy); end
        tests++; if (bus.f_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %0b exp 0", bus.f_ready); end
        push_word(64'h8, 32'hA8);
        tick();
        tests++; if (bus.occupancy !== 2'd2) begin fails++; $display("FAIL bp_hold_occ got %0d exp 2", bus.occupancy); end
        tests++; if (bus.d_pc !== 64'h0) begin fails++; $display("FAIL bp_hold_pc got %h exp 0", bus.d_pc); end
        tests++; if (bus.d_instruction !== 32'hA0) begin fails++; $display("FAIL bp_hold_instr got %h exp a0", bus.d_instruction); end
        bus.d_ready = 1'b1;
        tick();
        tests++; if (bus.occupancy !== 2'd1) begin fails++; $display("FAIL bp_pop1_occ got %0d exp 1", bus.occupancy); end
        tests++; if (bus.d_pc !== 64'h4) begin fails++; $display("FAIL bp_pop1_pc got %h exp 4", bus.d_pc); end
        tests++; if (bus.f_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_rise got %0b exp 1", bus.f_ready); end
        tick();
        bus.f_valid = 1'b0;
        tests++; if (bus.d_pc !== 64'h8) begin fails++; $display("FAIL bp_pop2_pc got %h exp 8", bus.d_pc); end
        tests++; if (bus.d_instruction !== 32'hA8) begin fails++; $display("FAIL bp_pop2_instr got %h exp a8", bus.d_instruction); end
        tests++; if (bus.occupancy !== 2'd1) begin fails++; $display("FAIL bp_pop2_occ got %0d exp 1", bus.occupancy); end
        tick();
        tests++; if (bus.occupancy !== 2'd0) begin fails++; $display("FAIL bp_drain_occ got %0d exp 0", bus.occupancy); end
        idle_inputs();
    endtask

    task automatic test_stream();
        push_word(64'h0, 32'h100);
        tick();
        for (int i = 0; i < 8; i++) begin
            tests++; if (bus.occupancy !== 2'd1) begin fails++; $display("FAIL stream_occ[%0d] got %0d exp 1", i, bus.occupancy); end
            tests++; if (bus.d_pc !== 64'(4 * i)) begin fails++; $display("FAIL stream_pc[%0d] got %h exp %h", i, bus.d_pc, 64'(4 * i)); end
            push_word(64'(4 * (i + 1)), 32'(32'h100 + i + 1));
            bus.d_ready = 1'b1;
            tick();
        end
        bus.f_valid = 1'b0;
        tick();
        tests++; if (bus.occupancy !== 2'd0) begin fails++; $display("FAIL stream_drain got %0d exp 0", bus.occupancy); end
        idle_inputs();
    endtask

    task automatic test_flush();
        push_word(64'h10, 32'hB0);
        tick();
        push_word(64'h14, 32'hB4);
        tick();
        tests++; if (bus.occupancy !== 2'd2) begin fails++; $display("FAIL flush_pre_occ got %0d exp 2", bus.occupancy); end
        push_word(64'h40, 32'hDEAD);
        bus.flush   = 1'b1;
        bus.d_ready = 1'b1;
        tests++; if (bus.f_ready !== 1'b0) begin fails++; $display("FAIL flush_f_ready got %0b exp 0", bus.f_ready); end
        tick();
        idle_inputs();
        tests++; if (bus.d_valid !== 1'b0) begin fails++; $display("FAIL flush_d_valid got %0b exp 0", bus.d_valid); end
        tests++; if (bus.occupancy !== 2'd0) begin fails++; $display("FAIL flush_occ got %0d exp 0", bus.occupancy); end
        tests++; if (bus.d_pc !== 64'h0) begin fails++; $display("FAIL flush_d_pc got %h exp 0", bus.d_pc); end
        push_word(64'h100, 32'hC0);
        tick();
        bus.f_valid = 1'b0;
        tests++; if (bus.d_pc !== 64'h100) begin fails++; $display("FAIL flush_next_pc got %h exp 100", bus.d_pc); end
        tests++; if (bus.occupancy !== 2'd1) begin fails++; $display("FAIL flush_next_occ got %0d exp 1", bus.occupancy); end
        bus.d_ready = 1'b1;
        tick();
        tests++; if (bus.occupancy !== 2'd0) begin fails++; $display("FAIL flush_alone_occ got %0d exp 0", bus.occupancy); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        push_word(64'hFFFF_FFFF_FFFF_FFFC, 32'hE0);
        tick();
        bus.f_valid = 1'b0;
        tests++; if (bus.d_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin fails++; $display("FAIL wrap_pc got %h exp fffffffffffffffc", bus.d_pc); end
        tests++; if (bus.d_pc_plus4 !== 64'h0) begin fails++; $display("FAIL wrap_pc4 got %h exp 0", bus.d_pc_plus4); end
        bus.d_ready = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_async_reset();
        push_word(64'h20, 32'hF0);
        tick();
        push_word(64'h24, 32'hF4);
        tick();
        bus.f_valid = 1'b0;
        tests++; if (bus.occupancy !== 2'd2) begin fails++; $display("FAIL areset_pre_occ got %0d exp 2", bus.occupancy); end
        #2;
        reset_n = 1'b0;
        #1;
        tests++; if (bus.d_valid !== 1'b0) begin fails++; $display("FAIL areset_d_valid got %0b exp 0", bus.d_valid); end
        tests++; if (bus.occupancy !== 2'd0) begin fails++; $display("FAIL areset_occ got %0d exp 0", bus.occupancy); end
        tests++; if (bus.d_pc !== 64'h0) begin fails++; $display("FAIL areset_d_pc got %h exp 0", bus.d_pc); end
        #4;
        reset_n = 1'b1;
        tick();
        tests++; if (bus.f_ready !== 1'b1) begin fails++; $display("FAIL areset_post_ready got %0b exp 1", bus.f_ready); end
        tests++; if (bus.occupancy !== 2'd0) begin fails++; $display("FAIL areset_post_occ got %0d exp 0", bus.occupancy); end
        tests++; if (bus.d_valid !== 1'b0) begin fails++; $display("FAIL areset_post_valid got %0b exp 0", bus.d_valid); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
